// File: rtl/pe_kl_config_ctrl.sv
`default_nettype none
// pe_kl_config_ctrl: flush PE config, broadcast host key/lock entries with a fixed-width strobe,
// settle, then pulse done. Rev 1.0
module pe_kl_config_ctrl #(
  parameter int ROW_BUS_WIDTH = 2,
  parameter int COL_BUS_WIDTH = 2,
  parameter int FLUSH_CYCLES  = 4,
  parameter int HOLD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 10,
  parameter int MAX_ENTRIES   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ROW_BUS_WIDTH-1:0]         cmd_row,
  input  logic [COL_BUS_WIDTH-1:0]         cmd_col,
  input  logic                             cmd_type,
  input  logic                             cmd_last,
  output logic                             kl_flush,
  output logic                             kl_valid,
  output logic [ROW_BUS_WIDTH-1:0]         kl_row,
  output logic [COL_BUS_WIDTH-1:0]         kl_col,
  output logic                             kl_type,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(MAX_ENTRIES+1)-1:0] entry_count,
  output logic                             err_overflow
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FLUSH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int CNT_MAX = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int EC_W    = $clog2(MAX_ENTRIES + 1);

  logic [2:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic                     final_q, final_d;
  logic                     kl_flush_q, kl_flush_d;
  logic                     kl_valid_q, kl_valid_d;
  logic [ROW_BUS_WIDTH-1:0] kl_row_q, kl_row_d;
  logic [COL_BUS_WIDTH-1:0] kl_col_q, kl_col_d;
  logic                     kl_type_q, kl_type_d;
  logic                     done_q, done_d;
  logic [EC_W-1:0]          count_q, count_d;
  logic                     err_q, err_d;
  logic                     xfer;

  assign cmd_ready = (state_q == S_LOAD) && (hold_q == '0);
  assign xfer      = cmd_valid && cmd_ready;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    final_d    = final_q;
    kl_flush_d = 1'b0;
    kl_valid_d = 1'b0;
    kl_row_d   = kl_row_q;
    kl_col_d   = kl_col_q;
    kl_type_d  = kl_type_q;
    done_d     = 1'b0;
    count_d    = count_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FLUSH;
          cnt_d      = CNT_W'(FLUSH_CYCLES - 1);
          kl_flush_d = 1'b1;
          count_d    = '0;
          err_d      = 1'b0;
          final_d    = 1'b0;
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = S_LOAD;
        end else begin
          cnt_d      = cnt_q - 1'b1;
          kl_flush_d = 1'b1;
        end
      end
      S_LOAD: begin
        // hold_q counts down the strobe; reaching zero forces the idle gap cycle
        if (hold_q != '0) begin
          hold_d     = hold_q - 1'b1;
          kl_valid_d = (hold_q > HOLD_W'(1));
          if ((hold_q == HOLD_W'(1)) && final_q) begin
            state_d = S_SETTLE;
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          end
        end else if (xfer) begin
          hold_d     = HOLD_W'(HOLD_CYCLES);
          kl_valid_d = 1'b1;
          kl_row_d   = cmd_row;
          kl_col_d   = cmd_col;
          kl_type_d  = cmd_type;
          count_d    = count_q + 1'b1;
          if (count_q == EC_W'(MAX_ENTRIES - 1)) begin
            final_d = 1'b1;
            if (!cmd_last) err_d = 1'b1;
          end else if (cmd_last) begin
            final_d = 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      final_q    <= 1'b0;
      kl_flush_q <= 1'b0;
      kl_valid_q <= 1'b0;
      kl_row_q   <= '0;
      kl_col_q   <= '0;
      kl_type_q  <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      final_q    <= final_d;
      kl_flush_q <= kl_flush_d;
      kl_valid_q <= kl_valid_d;
      kl_row_q   <= kl_row_d;
      kl_col_q   <= kl_col_d;
      kl_type_q  <= kl_type_d;
      done_q     <= done_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  assign kl_flush     = kl_flush_q;
  assign kl_valid     = kl_valid_q;
  assign kl_row       = kl_row_q;
  assign kl_col       = kl_col_q;
  assign kl_type      = kl_type_q;
  assign done         = done_q;
  assign entry_count  = count_q;
  assign err_overflow = err_q;
endmodule
`default_nettype wire
